// File: rtl/audio_rate_gen_if.sv
// ==== audio_rate_gen_if : control/status bundle for the sample-rate generator | rev 1.0 ====
`default_nettype none
`timescale 1ns/1ps

interface audio_rate_gen_if;
    logic       enable;
    logic [1:0] rate_sel;
    logic       audio_stb;
    logic       audio_stb_fall;
    logic       audio_clk;
    logic [1:0] rate_cur;

    modport master (
        output enable,
        output rate_sel,
        input  audio_stb,
        input  audio_stb_fall,
        input  audio_clk,
        input  rate_cur
    );

    modport slave (
        input  enable,
        input  rate_sel,
        output audio_stb,
        output audio_stb_fall,
        output audio_clk,
        output rate_cur
    );
endinterface

`default_nettype wire

// File: rtl/audio_rate_gen.sv
// ==== audio_rate_gen : fractional-accumulator audio sample clock / strobe generator | rev 1.0 ====
`default_nettype none
`timescale 1ns/1ps

module audio_rate_gen #(
    parameter int CLKRATE = 28000000,
    parameter int RATE0   = 48000,
    parameter int RATE1   = 44100,
    parameter int RATE2   = 96000,
    parameter int RATE3   = 192000
) (
    input  logic             clk,
    input  logic             reset_n,
    audio_rate_gen_if.slave  bus
);

    localparam int c_ACC_W = $clog2(CLKRATE) + 1;
    localparam int c_SUM_W = c_ACC_W + 1;
    localparam logic [c_SUM_W-1:0] c_CLK_SUM = c_SUM_W'(CLKRATE);

    generate
        if (!(RATE0 > 0 && 2*RATE0 < CLKRATE &&
              RATE1 > 0 && 2*RATE1 < CLKRATE &&
              RATE2 > 0 && 2*RATE2 < CLKRATE &&
              RATE3 > 0 && 2*RATE3 < CLKRATE)) begin : g_bad_rate
            $fatal(1, "audio_rate_gen: every RATEx must satisfy 0 < 2*RATEx < CLKRATE");
        end
    endgenerate

    // One accumulator wrap per half-period, hence twice the sample rate.
    function automatic logic [c_ACC_W-1:0] inc_for(input logic [1:0] sel);
        logic [c_ACC_W-1:0] v;
        case (sel)
            2'd0:    v = c_ACC_W'(2*RATE0);
            2'd1:    v = c_ACC_W'(2*RATE1);
            2'd2:    v = c_ACC_W'(2*RATE2);
            default: v = c_ACC_W'(2*RATE3);
        endcase
        return v;
    endfunction

    logic [c_ACC_W-1:0] r_acc;
    logic [c_ACC_W-1:0] r_inc;
    logic [1:0]         r_rate_cur;
    logic               r_audio_clk;
    logic               r_stb;
    logic               r_stb_fall;

    logic [c_SUM_W-1:0] w_sum;
    logic               w_tick;

    assign w_sum  = {1'b0, r_acc} + {1'b0, r_inc};
    assign w_tick = (w_sum >= c_CLK_SUM);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc       <= '0;
            r_inc       <= inc_for(2'd0);
            r_rate_cur  <= 2'd0;
            r_audio_clk <= 1'b0;
            r_stb       <= 1'b0;
            r_stb_fall  <= 1'b0;
        end else if (!bus.enable) begin
            r_acc       <= '0;
            r_inc       <= inc_for(bus.rate_sel);
            r_rate_cur  <= bus.rate_sel;
            r_audio_clk <= 1'b0;
            r_stb       <= 1'b0;
            r_stb_fall  <= 1'b0;
        end else begin
            r_stb      <= 1'b0;
            r_stb_fall <= 1'b0;
            if (w_tick) begin
                r_acc       <= c_ACC_W'(w_sum - c_CLK_SUM);
                r_audio_clk <= ~r_audio_clk;
                if (!r_audio_clk) begin
                    // Rate switches only at a rising edge so no runt half-period appears.
                    r_stb      <= 1'b1;
                    r_rate_cur <= bus.rate_sel;
                    r_inc      <= inc_for(bus.rate_sel);
                end else begin
                    r_stb_fall <= 1'b1;
                end
            end else begin
                r_acc <= c_ACC_W'(w_sum);
            end
        end
    end

    assign bus.audio_stb      = r_stb;
    assign bus.audio_stb_fall = r_stb_fall;
    assign bus.audio_clk      = r_audio_clk;
    assign bus.rate_cur       = r_rate_cur;

endmodule

`default_nettype wire

// File: tb/tb_audio_rate_gen.sv
// ==== tb_audio_rate_gen : scoreboard bench for audio_rate_gen | rev 1.0 ====
`default_nettype none
`timescale 1ns/1ps

module tb_audio_rate_gen;

    localparam int CLK_HZ = 100;
    localparam int R0 = 10;
    localparam int R1 = 15;
    localparam int R2 = 20;
    localparam int R3 = 40;

    typedef struct packed {
        logic       stb;
        logic       fall;
        logic       aclk;
        logic [1:0] rate;
    } out_t;

    logic clk = 1'b0;
    logic reset_n;
    logic reset_n_p;

    always #5 clk = ~clk;

    audio_rate_gen_if bus();
    audio_rate_gen_if bus_p();

    audio_rate_gen #(
        .CLKRATE(CLK_HZ), .RATE0(R0), .RATE1(R1), .RATE2(R2), .RATE3(R3)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    audio_rate_gen #(
        .CLKRATE(28000000), .RATE0(48000), .RATE1(44100), .RATE2(96000), .RATE3(192000)
    ) dut_p (
        .clk(clk), .reset_n(reset_n_p), .bus(bus_p)
    );

    out_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference: total phase since the run began, in units where CLKRATE = one half-period.
    // audio_clk is the parity of the number of completed half-periods.
    longint     m_phase;
    longint     m_half;
    logic       m_clk;
    logic [1:0] m_rate;

    function automatic longint rate_hz(input logic [1:0] s);
        case (s)
            2'd0:    return R0;
            2'd1:    return R1;
            2'd2:    return R2;
            default: return R3;
        endcase
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_half  = 0;
        m_clk   = 1'b0;
        m_rate  = 2'd0;
    endtask

    // Called at a falling edge: drive inputs, predict outputs after the next rising edge.
    task automatic step(input logic en, input logic [1:0] sel);
        out_t e;
        bus.enable   = en;
        bus.rate_sel = sel;
        e = '0;
        if (!en) begin
            m_phase = 0;
            m_half  = 0;
            m_clk   = 1'b0;
            m_rate  = sel;
        end else begin
            m_phase += 2 * rate_hz(m_rate);
            if (m_phase / CLK_HZ != m_half) begin
                m_half = m_phase / CLK_HZ;
                m_clk  = m_half[0];
                if (m_clk) begin
                    e.stb  = 1'b1;
                    m_rate = sel;
                end else begin
                    e.fall = 1'b1;
                end
            end
        end
        e.aclk = m_clk;
        e.rate = m_rate;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_stb"},  bus.audio_stb, 0);
        check({tag, "_fall"}, bus.audio_stb_fall, 0);
        check({tag, "_clk"},  bus.audio_clk, 0);
        check({tag, "_rate"}, bus.rate_cur, 0);
    endtask

    task automatic do_reset(input logic en, input logic [1:0] sel);
        @(negedge clk);
        reset_n      = 1'b0;
        bus.enable   = en;
        bus.rate_sel = sel;
        @(negedge clk);
        @(negedge clk);
        check_zero("reset");
        model_reset();
        reset_n = 1'b1;
    endtask

    // Monitor: compares every registered output cycle against the scoreboard.
    initial begin
        out_t e;
        out_t got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {bus.audio_stb, bus.audio_stb_fall, bus.audio_clk, bus.rate_cur};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL cycle_outputs: got stb=%b fall=%b clk=%b rate=%0d expected stb=%b fall=%b clk=%b rate=%0d (t=%0t)",
                             got.stb, got.fall, got.aclk, got.rate, e.stb, e.fall, e.aclk, e.rate, $time);
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         first;
        int         n_stb;
        int         n_fall;
        int         ra;
        int         sb;
        logic       en;
        logic [1:0] sel;

        reset_n       = 1'b0;
        reset_n_p     = 1'b0;
        bus.enable    = 1'b1;
        bus.rate_sel  = 2'd0;
        bus_p.enable  = 1'b0;
        bus_p.rate_sel = 2'd3;

        // Integer divide from reset.
        do_reset(1'b1, 2'd0);
        first = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1'b1, 2'd0);
            if (first == 0 && bus.audio_stb) first = i;
        end
        check("first_stb_rate0", first, 5);

        // Fractional rate: first tick still at rate 0, then 3/3/4 spacing.
        do_reset(1'b1, 2'd1);
        n_stb = 0;
        n_fall = 0;
        for (int i = 1; i <= 210; i++) begin
            step(1'b1, 2'd1);
            if (i >= 6 && i <= 205) begin
                n_stb  += int'(bus.audio_stb);
                n_fall += int'(bus.audio_stb_fall);
            end
        end
        check("frac_stb_count", n_stb, 30);
        check("frac_fall_count", n_fall, 30);

        // Mid-period rate change takes effect on the next rising tick (edge 15).
        do_reset(1'b1, 2'd0);
        for (int i = 1; i <= 8; i++) step(1'b1, 2'd0);
        ra = 0;
        sb = 0;
        for (int i = 9; i <= 38; i++) begin
            step(1'b1, 2'd3);
            if (ra == 0 && bus.rate_cur == 2'd3) begin
                ra = i;
                sb = int'(bus.audio_stb);
            end
        end
        check("rate_change_edge", ra, 15);
        check("rate_change_with_stb", sb, 1);

        // Change on the exact rising-tick edge, withdrawn right after.
        do_reset(1'b1, 2'd0);
        for (int i = 1; i <= 14; i++) step(1'b1, 2'd0);
        step(1'b1, 2'd2);
        check("simul_rate", bus.rate_cur, 2);
        check("simul_stb", bus.audio_stb, 1);
        for (int i = 0; i < 12; i++) step(1'b1, 2'd0);

        // Enable toggle mid-period.
        for (int i = 0; i < 3; i++) step(1'b1, 2'd0);
        step(1'b0, 2'd0);
        check_zero("disable");
        for (int i = 0; i < 6; i++) step(1'b0, 2'd0);
        first = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 2'd0);
            if (first == 0 && bus.audio_stb) first = i;
        end
        check("reenable_first_stb", first, 5);

        // Randomized run: mostly enabled, rate_sel wanders.
        sel = 2'd0;
        for (int i = 0; i < 1500; i++) begin
            en = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 7) == 0) sel = 2'($urandom_range(0, 3));
            step(en, sel);
        end

        // Asynchronous reset while audio_clk is high, between clock edges.
        for (int i = 0; i < 20 && !bus.audio_clk; i++) step(1'b1, 2'd0);
        check("async_pre_clk_high", bus.audio_clk, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("async_reset");
        check("scoreboard_drained", exp_q.size(), 0);

        // Production rates: enable low first so rate 3 is loaded before running.
        @(negedge clk);
        reset_n_p = 1'b1;
        @(negedge clk);
        bus_p.enable = 1'b1;
        first = 0;
        for (int i = 1; i <= 400 && first == 0; i++) begin
            @(negedge clk);
            if (bus_p.audio_stb) first = i;
        end
        check("prod_first_stb", first, 73);
        check("prod_rate_cur", bus_p.rate_cur, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
